// File: rtl/peripherals_gpio.sv
// peripherals_gpio: memory-mapped GPIO block.
//   Word registers at address[4:2]:
//     0 OUT (RW), 1 IN (RO, debounced), 2 FLAGS (W1C), 3 RISE_EN (RW),
//     4 FALL_EN (RW), 5..7 read zero and ignore writes.
// Ports:
//   clock, reset             system clock, synchronous active-high reset
//   address, input_data,     bus address, write data and write strobe
//   should_write
//   output_data              combinational read data (zero-extended)
//   input_peripherals        asynchronous pins -> synchroniser + debouncer
//   output_peripherals       registered pins, OUT ^ OUTPUT_INVERT_MASK
//   irq                      registered OR of FLAGS

// Per-input lane: synchroniser, debouncer and edge pulses.
//   pin        raw asynchronous input
//   debounced  filtered value
//   rise/fall  one-cycle pulses in the cycle right after debounced changes
module gpio_in_lane #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic pin,
  output logic debounced,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   deb_q, deb_prev_q, s;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q     <= '0;
      cnt_q      <= '0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], pin};
      deb_prev_q <= deb_q;
      if (s == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        // the increment would hit DEBOUNCE_CYCLES: accept the new level
        deb_q <= s;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign debounced = deb_q;
  assign rise      =  deb_q & ~deb_prev_q;
  assign fall      = ~deb_q &  deb_prev_q;
endmodule

module peripherals_gpio #(
  parameter int                     NUM_INPUTS         = 4,
  parameter int                     NUM_OUTPUTS        = 4,
  parameter logic [NUM_OUTPUTS-1:0] OUTPUT_INVERT_MASK = 4'b1100,
  parameter int                     SYNC_STAGES        = 2,
  parameter int                     DEBOUNCE_CYCLES    = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [31:0]            address,
  input  logic [31:0]            input_data,
  input  logic                   should_write,
  output logic [31:0]            output_data,
  input  logic [NUM_INPUTS-1:0]  input_peripherals,
  output logic [NUM_OUTPUTS-1:0] output_peripherals,
  output logic                   irq
);
  typedef enum logic [2:0] {
    R_OUT = 3'd0, R_IN = 3'd1, R_FLAGS = 3'd2, R_RISE = 3'd3, R_FALL = 3'd4
  } reg_e;

  logic [NUM_OUTPUTS-1:0] out_q, pins_q;
  logic [NUM_INPUTS-1:0]  flags_q, rise_en_q, fall_en_q;
  logic [NUM_INPUTS-1:0]  deb, rise, fall, set_vec, clr_vec;
  logic [2:0]             sel;
  logic                   irq_q;

  assign sel = address[4:2];

  genvar i;
  generate
    for (i = 0; i < NUM_INPUTS; i++) begin : g_lane
      gpio_in_lane #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_lane (
        .clock    (clock),
        .reset    (reset),
        .pin      (input_peripherals[i]),
        .debounced(deb[i]),
        .rise     (rise[i]),
        .fall     (fall[i])
      );
    end
  endgenerate

  // New edges are OR'd in after the clear so a same-cycle set beats W1C.
  assign set_vec = (rise & rise_en_q) | (fall & fall_en_q);
  assign clr_vec = (should_write && sel == R_FLAGS) ? input_data[NUM_INPUTS-1:0] : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      out_q     <= '0;
      pins_q    <= OUTPUT_INVERT_MASK;
      rise_en_q <= '0;
      fall_en_q <= '0;
      flags_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      if (should_write && sel == R_OUT) begin
        out_q  <= input_data[NUM_OUTPUTS-1:0];
        pins_q <= input_data[NUM_OUTPUTS-1:0] ^ OUTPUT_INVERT_MASK;
      end
      if (should_write && sel == R_RISE) rise_en_q <= input_data[NUM_INPUTS-1:0];
      if (should_write && sel == R_FALL) fall_en_q <= input_data[NUM_INPUTS-1:0];
      flags_q <= (flags_q & ~clr_vec) | set_vec;
      irq_q   <= |flags_q;
    end
  end

  always_comb begin
    output_data = '0;
    case (sel)
      R_OUT:   output_data[NUM_OUTPUTS-1:0] = out_q;
      R_IN:    output_data[NUM_INPUTS-1:0]  = deb;
      R_FLAGS: output_data[NUM_INPUTS-1:0]  = flags_q;
      R_RISE:  output_data[NUM_INPUTS-1:0]  = rise_en_q;
      R_FALL:  output_data[NUM_INPUTS-1:0]  = fall_en_q;
      default: output_data = '0;
    endcase
  end

  assign output_peripherals = pins_q;
  assign irq                = irq_q;

  // address bits outside [4:2] and upper write-data bits are don't-care
  logic unused_bits;
  assign unused_bits = &{1'b0, address[31:5], address[1:0], input_data};
endmodule
